// File: rtl/operand_shift_register.sv
// Multi-mode operand shift register: loads via valid/ready, shifts Shift_Bits per enabled step,
// counts remaining steps and pulses done (optionally early on an exhausted operand).
module operand_shift_register #(
  parameter int Word_Length = 8,
  parameter int Shift_Bits  = 1,
  localparam int Steps = Word_Length / Shift_Bits,
  localparam int Cnt_W = $clog2(Steps + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [Word_Length-1:0] data_in,
  input  logic [1:0]             mode_in,
  input  logic                   early_term_en,
  input  logic                   shift_en,
  output logic [Word_Length-1:0] data_out,
  output logic [Shift_Bits-1:0]  out_bits,
  output logic [Cnt_W-1:0]       steps_left,
  output logic                   busy,
  output logic                   done
);

  if (Word_Length < 2 || (Word_Length % Shift_Bits) != 0) begin : g_param_check
    $error("operand_shift_register: Shift_Bits must divide Word_Length and Word_Length must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [1:0] ModeLsr = 2'b00;
  localparam logic [1:0] ModeAsr = 2'b01;
  localparam logic [1:0] ModeLsl = 2'b10;

  state_t                 state_q, state_d;
  logic [Word_Length-1:0] data_q, data_d;
  logic [1:0]             mode_q, mode_d;
  logic                   et_q, et_d;
  logic [Cnt_W-1:0]       steps_q, steps_d;
  logic [Word_Length-1:0] shifted;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      mode_q  <= 2'b00;
      et_q    <= 1'b0;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      et_q    <= et_d;
      steps_q <= steps_d;
    end
  end

  // Rotation as two shifts stays legal even when one step consumes the whole word.
  always_comb begin
    case (mode_q)
      ModeLsr: shifted = data_q >> Shift_Bits;
      ModeAsr: shifted = $signed(data_q) >>> Shift_Bits;
      ModeLsl: shifted = data_q << Shift_Bits;
      default: shifted = (data_q >> Shift_Bits) | (data_q << (Word_Length - Shift_Bits));
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mode_d  = mode_q;
    et_d    = et_q;
    steps_d = steps_q;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          data_d  = data_in;
          mode_d  = mode_in;
          et_d    = early_term_en;
          steps_d = Cnt_W'(Steps);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          data_d  = shifted;
          steps_d = steps_q - Cnt_W'(1);
          // Early exit only makes sense for zero-filling modes; sign fill and rotate never drain.
          if (steps_q == Cnt_W'(1) || (et_q && !mode_q[0] && shifted == '0)) begin
            steps_d = '0;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign data_out   = data_q;
  assign steps_left = steps_q;
  assign out_bits   = (mode_q == ModeLsl) ? data_q[Word_Length-1 -: Shift_Bits]
                                          : data_q[Shift_Bits-1:0];

endmodule

// File: tb/tb_operand_shift_register.sv
// Scoreboard bench for operand_shift_register: one instance with 1-bit steps, one with 2-bit steps.
module tb_operand_shift_register;

  typedef struct {
    logic [7:0] data;
    logic [3:0] steps;
    logic [1:0] bits;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       lv1 = 0, lr1, et1 = 0, se1 = 0, busy1, done1;
  logic [7:0] din1 = 0, dout1;
  logic [1:0] mode1 = 0;
  logic [0:0] ob1;
  logic [3:0] sl1;

  logic       lv2 = 0, lr2, et2 = 0, se2 = 0, busy2, done2;
  logic [7:0] din2 = 0, dout2;
  logic [1:0] mode2 = 0;
  logic [1:0] ob2;
  logic [2:0] sl2;

  operand_shift_register #(.Word_Length(8), .Shift_Bits(1)) u_s1 (
    .clk(clk), .reset(reset), .load_valid(lv1), .load_ready(lr1), .data_in(din1),
    .mode_in(mode1), .early_term_en(et1), .shift_en(se1), .data_out(dout1),
    .out_bits(ob1), .steps_left(sl1), .busy(busy1), .done(done1));

  operand_shift_register #(.Word_Length(8), .Shift_Bits(2)) u_s2 (
    .clk(clk), .reset(reset), .load_valid(lv2), .load_ready(lr2), .data_in(din2),
    .mode_in(mode2), .early_term_en(et2), .shift_en(se2), .data_out(dout2),
    .out_bits(ob2), .steps_left(sl2), .busy(busy2), .done(done2));

  exp_t step_q1[$], done_q1[$], step_q2[$], done_q2[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_step(input int inst, input logic [7:0] d, input logic [3:0] s, input logic [1:0] b);
    exp_t e;
    e.data = d; e.steps = s; e.bits = b;
    if (inst == 1) step_q1.push_back(e); else step_q2.push_back(e);
  endtask

  task automatic push_done(input int inst, input logic [7:0] d);
    exp_t e;
    e.data = d; e.steps = 4'd0; e.bits = 2'd0;
    if (inst == 1) done_q1.push_back(e); else done_q2.push_back(e);
  endtask

  // Monitor: a step is consumed on every edge where the block is busy with shift_en high.
  always @(negedge clk) begin
    exp_t e;
    if (busy1 && se1) begin
      if (step_q1.size() == 0) check("s1_step_unexpected", 32'd1, 32'd0);
      else begin
        e = step_q1.pop_front();
        check("s1_step", {8'(ob1), dout1, 4'(sl1)}, {8'(e.bits), e.data, e.steps});
      end
    end
    if (done1) begin
      if (done_q1.size() == 0) check("s1_done_unexpected", 32'd1, 32'd0);
      else begin
        e = done_q1.pop_front();
        check("s1_done", {dout1, 4'(sl1), busy1, lr1}, {e.data, e.steps, 2'b00});
      end
    end
    if (busy2 && se2) begin
      if (step_q2.size() == 0) check("s2_step_unexpected", 32'd1, 32'd0);
      else begin
        e = step_q2.pop_front();
        check("s2_step", {8'(ob2), dout2, 4'(sl2)}, {8'(e.bits), e.data, e.steps});
      end
    end
    if (done2) begin
      if (done_q2.size() == 0) check("s2_done_unexpected", 32'd1, 32'd0);
      else begin
        e = done_q2.pop_front();
        check("s2_done", {dout2, 4'(sl2), busy2, lr2}, {e.data, e.steps, 2'b00});
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load(input int inst, input logic [7:0] d, input logic [1:0] m, input logic et);
    if (inst == 1) begin lv1 = 1; din1 = d; mode1 = m; et1 = et; end
    else           begin lv2 = 1; din2 = d; mode2 = m; et2 = et; end
    cycles(1);
    lv1 = 0; lv2 = 0;
  endtask

  task automatic shift(input int inst, input int n);
    if (inst == 1) se1 = 1; else se2 = 1;
    cycles(n);
    se1 = 0; se2 = 0;
  endtask

  initial begin
    #3;
    check("reset_s1", {dout1, 4'(sl1), 1'(ob1), busy1, done1}, 32'd0);
    check("reset_s2", {dout2, 1'(sl2), ob2, busy2, done2}, 32'd0);
    #4 reset = 0;
    cycles(1);
    check("ready_after_reset", {lr1, lr2}, 2'b11);

    // Logical right 0xB5, shift_en held (also high while idle, where it must be ignored)
    se1 = 1;
    cycles(1);
    push_step(1, 8'hB5, 8, 1); push_step(1, 8'h5A, 7, 0); push_step(1, 8'h2D, 6, 1); push_step(1, 8'h16, 5, 0);
    push_step(1, 8'h0B, 4, 1); push_step(1, 8'h05, 3, 1); push_step(1, 8'h02, 2, 0); push_step(1, 8'h01, 1, 1);
    push_done(1, 8'h00);
    check("idle_ignores_shift", {dout1, 4'(sl1), busy1}, 13'd0);
    load(1, 8'hB5, 2'b00, 0);
    shift(1, 8);
    cycles(1);
    check("ready_after_done", {lr1, busy1, done1}, 3'b100);

    // Arithmetic right 0x90 with a gap; a load attempt during the gap must be ignored
    push_step(1, 8'h90, 8, 0); push_step(1, 8'hC8, 7, 0); push_step(1, 8'hE4, 6, 0);
    push_step(1, 8'hF2, 5, 0); push_step(1, 8'hF9, 4, 1); push_step(1, 8'hFC, 3, 0);
    push_step(1, 8'hFE, 2, 0); push_step(1, 8'hFF, 1, 1);
    push_done(1, 8'hFF);
    load(1, 8'h90, 2'b01, 0);
    shift(1, 3);
    lv1 = 1; din1 = 8'h55; mode1 = 2'b10;
    cycles(4);
    lv1 = 0;
    check("gap_hold", {dout1, 4'(sl1), busy1, lr1}, {8'hF2, 4'd5, 2'b10});
    shift(1, 5);
    cycles(1);

    // Two-bit steps: logical right then rotate right
    push_step(2, 8'hB5, 4, 1); push_step(2, 8'h2D, 3, 1); push_step(2, 8'h0B, 2, 3); push_step(2, 8'h02, 1, 2);
    push_done(2, 8'h00);
    load(2, 8'hB5, 2'b00, 0);
    shift(2, 4);
    cycles(1);
    push_step(2, 8'hB5, 4, 1); push_step(2, 8'h6D, 3, 1); push_step(2, 8'h5B, 2, 3); push_step(2, 8'hD6, 1, 2);
    push_done(2, 8'hB5);
    load(2, 8'hB5, 2'b11, 1);
    shift(2, 4);
    cycles(1);
    check("rotate_restores", dout2, 8'hB5);

    // Early termination on an exhausted operand, then the same operand without it
    push_step(1, 8'h03, 8, 1); push_step(1, 8'h01, 7, 1);
    push_done(1, 8'h00);
    load(1, 8'h03, 2'b00, 1);
    shift(1, 2);
    check("early_term_state", {done1, busy1, 4'(sl1)}, {2'b10, 4'd0});
    cycles(1);
    push_step(1, 8'h03, 8, 1); push_step(1, 8'h01, 7, 1);
    for (int i = 6; i >= 1; i--) push_step(1, 8'h00, 4'(i), 0);
    push_done(1, 8'h00);
    load(1, 8'h03, 2'b00, 0);
    shift(1, 8);
    cycles(1);

    // Logical left 0x81
    push_step(1, 8'h81, 8, 1); push_step(1, 8'h02, 7, 0); push_step(1, 8'h04, 6, 0); push_step(1, 8'h08, 5, 0);
    push_step(1, 8'h10, 4, 0); push_step(1, 8'h20, 3, 0); push_step(1, 8'h40, 2, 0); push_step(1, 8'h80, 1, 1);
    push_done(1, 8'h00);
    load(1, 8'h81, 2'b10, 0);
    shift(1, 8);
    cycles(1);

    // Asynchronous reset after four steps, then a fresh operation
    push_step(1, 8'hB5, 8, 1); push_step(1, 8'h5A, 7, 0); push_step(1, 8'h2D, 6, 1); push_step(1, 8'h16, 5, 0);
    load(1, 8'hB5, 2'b00, 0);
    shift(1, 4);
    #2 reset = 1;
    #1;
    check("async_reset", {dout1, 4'(sl1), 1'(ob1), busy1, done1}, 32'd0);
    reset = 0;
    cycles(1);
    push_step(1, 8'h01, 8, 1);
    for (int i = 7; i >= 1; i--) push_step(1, 8'h00, 4'(i), 0);
    push_done(1, 8'h00);
    load(1, 8'h01, 2'b00, 0);
    shift(1, 8);
    cycles(3);

    check("s1_steps_drained", step_q1.size(), 0);
    check("s1_dones_drained", done_q1.size(), 0);
    check("s2_steps_drained", step_q2.size(), 0);
    check("s2_dones_drained", done_q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
